// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage definitions: instruction width, canonical NOP and
// the {addr, instr} bundle carried from fetch to decode.
package instr_fetch_queue_pkg;

    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] addr;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry circular queue of fetch_entry_t.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop, flush,
//        count (0..DEPTH), head (entry at read pointer).
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with a prefetch queue feeding decode.
// Ports: clk, rst_n (sync, active-low); imem_rd_en/imem_rd_addr out,
//        imem_rd_data in (1-cycle latency); redirect/redirect_addr in;
//        out_valid/out_addr/out_instr out, out_ready in.
// Optional macro FETCH_BYPASS_EN: response bypasses an empty queue.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd_en,
    output logic [31:0] imem_rd_addr,
    input  logic [31:0] imem_rd_data,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_instr
);

    localparam int               CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]      DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    fetch_entry_t    entry;
    logic [ILEN-1:0] fetch_pc;
    logic [ILEN-1:0] req_pc_q;
    logic [ILEN-1:0] redir_pc;
    logic            req_q;
    logic            resp_live;
    logic            credit_ok;
    logic            push;
    logic            pop;

    assign redir_pc = redirect_addr & ~32'h3;

    // Entries held plus the read in flight must leave room; a same-cycle
    // pop is deliberately not credited.
    assign credit_ok = ({1'b0, count} + {{CW{1'b0}}, req_q}) < DEPTH_C;

    assign imem_rd_en   = rst_n & (redirect | credit_ok);
    assign imem_rd_addr = redirect ? redir_pc : fetch_pc;

    // A response landing in a redirect cycle belongs to the old path.
    assign resp_live = req_q & ~redirect;
    assign push_data = '{addr: req_pc_q, instr: imem_rd_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc_q <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            req_q <= imem_rd_en;
            if (imem_rd_en) begin
                req_pc_q <= imem_rd_addr;
                fetch_pc <= imem_rd_addr + 32'd4;
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    logic byp;

    assign byp       = resp_live & (count == '0);
    assign push      = resp_live & ~(byp & out_ready);
    assign pop       = (count != '0) & out_ready & ~redirect;
    assign out_valid = rst_n & (byp | (count != '0));
    assign entry     = byp ? push_data : head;
`else
    assign push      = resp_live;
    assign pop       = (count != '0) & out_ready & ~redirect;
    assign out_valid = rst_n & (count != '0);
    assign entry     = head;
`endif

    assign out_addr  = entry.addr;
    assign out_instr = out_valid ? entry.instr : NOP_INSTR;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

endmodule
